dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous `DataMemory` between the core load/store path and a debug/loader port. It sits between the core's MEM stage and the data memory. It grants one access per cycle and routes read data back to the requester that issued the read. It raises a stall to the single-cycle core whenever the core's access is not granted, so the core holds its PC and register write-back.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 50 +++++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Holds the response-owner encoding, default bus widths and the fixed
// requester index assignment used by the arbiter and its round-robin core.

package dmem_arb_pkg;

  // Default bus geometry.
  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 32;

  // Requester slots in the two-bit request/grant vectors.
  localparam int IDX_CORE = 0;
  localparam int IDX_DBG  = 1;

  // Owner of the read accepted in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  // True when an accepted access is a read that will return data.
  function automatic logic is_read_accept(input logic gnt, input logic we);
    return gnt & ~we;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant generator.
// Grant is purely combinational from the requests, the force input and the
// registered last_win flag. last_win records which slot won the most recent
// contested, non-forced cycle; it resets to the debug slot so the core takes
// the first contest. force1 hands slot 1 the grant whenever it requests.

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       force1,
  output logic [1:0] gnt
);

  logic last_win;     // 0: slot 0 won last contest, 1: slot 1 won
  logic forced;
  logic contested;

  assign forced    = force1 & req[IDX_DBG];
  assign contested = req[IDX_CORE] & req[IDX_DBG] & ~forced;

  // Grant selection: forced slot 1 first, then round-robin on contest,
  // otherwise the lone requester (or nobody).
  always_comb begin
    gnt = 2'b00;
    if (forced) begin
      gnt[IDX_DBG] = 1'b1;
    end else if (contested) begin
      if (last_win) begin
        gnt[IDX_CORE] = 1'b1;
      end else begin
        gnt[IDX_DBG] = 1'b1;
      end
    end else begin
      gnt = req;
    end
  end

  // History flag moves only on contested, non-forced cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win <= 1'b1;
    end else if (contested) begin
      last_win <= gnt[IDX_DBG];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// core MEM stage and a debug/loader port. One access is granted per cycle;
// the winner's request is muxed onto the memory bus and read data is routed
// back one cycle later to whichever port issued the read.
//
// Build option: DMEM_ARB_LOCK_EN adds a debug lock. A debug acceptance with
// d_lock set holds the memory for the debug port (core stalls) until a debug
// acceptance with d_lock clear, or a cycle with d_req low. Without the macro
// d_lock is ignored and arbitration is plain round-robin.
//
// rsp_own   | meaning
// ----------+-----------------------------------------------
// OWN_NONE  | no read accepted last cycle; no rvalid
// OWN_CORE  | core read accepted last cycle; c_rvalid now
// OWN_DBG   | debug read accepted last cycle; d_rvalid now

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [XLEN-1:0]     c_wdata,
  input  logic [XLEN/8-1:0]   c_be,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [XLEN-1:0]     c_rdata,
  output logic                core_stall,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  input  logic [XLEN/8-1:0]   d_be,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [XLEN-1:0]     d_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic [XLEN-1:0]     mem_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       force_dbg;
  owner_t     rsp_own;
  owner_t     rsp_own_nxt;

  assign req[IDX_CORE] = c_req;
  assign req[IDX_DBG]  = d_req;

`ifdef DMEM_ARB_LOCK_EN
  logic lock;

  // Lock follows d_lock on each debug acceptance and drops when debug idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (!d_req) begin
      lock <= 1'b0;
    end else if (d_gnt) begin
      lock <= d_lock;
    end
  end

  assign force_dbg = lock;
`else
  logic unused_d_lock;

  assign unused_d_lock = d_lock;
  assign force_dbg     = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .force1 (force_dbg),
    .gnt    (gnt)
  );

  assign c_gnt      = gnt[IDX_CORE];
  assign d_gnt      = gnt[IDX_DBG];
  assign core_stall = c_req & ~c_gnt;
  assign mem_en     = c_gnt | d_gnt;

  // Memory bus carries the winner's request; idle bus is driven to zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_be    = c_be;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  // Next owner: whoever had a read accepted this cycle; writes leave none.
  always_comb begin
    rsp_own_nxt = OWN_NONE;
    if (is_read_accept(c_gnt, c_we)) begin
      rsp_own_nxt = OWN_CORE;
    end else if (is_read_accept(d_gnt, d_we)) begin
      rsp_own_nxt = OWN_DBG;
    end
  end

  // Response owner register; reset discards a read accepted in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_own <= OWN_NONE;
    end else begin
      rsp_own <= rsp_own_nxt;
    end
  end

  // Response demux: only the owner sees data, the other port reads zero.
  always_comb begin
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    c_rdata  = '0;
    d_rdata  = '0;
    case (rsp_own)
      OWN_CORE: begin
        c_rvalid = 1'b1;
        c_rdata  = mem_rdata;
      end
      OWN_DBG: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small synchronous
// memory behind the arbiter. Expected values are written out by hand.
// Lock steps are compiled in only when DMEM_ARB_LOCK_EN is defined.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_gnt, c_rvalid, core_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] mem [0:63];
  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory with byte enables, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move from the drive point to the falling edge (sample point).
  task automatic mid();
    #4;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]            = 32'h1111_0000;
    mem[1]            = 32'h2222_0004;
    mem[32'h10 >> 2]  = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;

    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0; d_lock = 0;

    // Reset state
    cyc(); cyc(); mid();
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Core alone reads 0x10
    cyc(); rst = 0;
    c_req = 1; c_we = 0; c_addr = 32'h10; c_be = 4'hF;
    mid();
    chk("c_rd_gnt", c_gnt, 1);
    chk("c_rd_stall", core_stall, 0);
    chk("c_rd_mem_addr", mem_addr, 32'h10);
    chk("c_rd_mem_we", mem_we, 0);
    cyc(); c_req = 0;
    mid();
    chk("c_rd_rvalid", c_rvalid, 1);
    chk("c_rd_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("c_rd_d_rvalid", d_rvalid, 0);
    chk("c_rd_d_rdata", d_rdata, 0);

    // Continuous contention with alternating reads: C, D, C, D
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h0; c_be = 4'hF;
    d_req = 1; d_we = 0; d_addr = 32'h4; d_be = 4'hF;
    mid();
    chk("rr0_c_gnt", c_gnt, 1);
    chk("rr0_d_gnt", d_gnt, 0);
    chk("rr0_stall", core_stall, 0);
    cyc(); mid();
    chk("rr1_d_gnt", d_gnt, 1);
    chk("rr1_c_gnt", c_gnt, 0);
    chk("rr1_stall", core_stall, 1);
    chk("rr1_mem_addr", mem_addr, 32'h4);
    chk("rr1_c_rvalid", c_rvalid, 1);
    chk("rr1_c_rdata", c_rdata, 32'h1111_0000);
    chk("rr1_d_rvalid", d_rvalid, 0);
    cyc(); mid();
    chk("rr2_c_gnt", c_gnt, 1);
    chk("rr2_stall", core_stall, 0);
    chk("rr2_d_rvalid", d_rvalid, 1);
    chk("rr2_d_rdata", d_rdata, 32'h2222_0004);
    chk("rr2_c_rvalid", c_rvalid, 0);
    chk("rr2_c_rdata", c_rdata, 0);
    cyc(); mid();
    chk("rr3_d_gnt", d_gnt, 1);
    chk("rr3_stall", core_stall, 1);
    chk("rr3_c_rdata", c_rdata, 32'h1111_0000);
    cyc(); c_req = 0; d_req = 0;
    mid();
    chk("rr4_d_rvalid", d_rvalid, 1);
    chk("rr4_c_rvalid", c_rvalid, 0);
    chk("rr4_d_rdata", d_rdata, 32'h2222_0004);
    chk("rr4_mem_en", mem_en, 0);
    chk("rr4_mem_wdata", mem_wdata, 0);

    // Debug writes 0x12345678 to 0x20, core reads it back
    cyc();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_be = 4'hF;
    mid();
    chk("dwr_d_gnt", d_gnt, 1);
    chk("dwr_mem_we", mem_we, 1);
    chk("dwr_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("dwr_mem_be", mem_be, 4'hF);
    cyc(); d_req = 0;
    c_req = 1; c_we = 0; c_addr = 32'h20;
    mid();
    chk("dwr_no_d_rvalid", d_rvalid, 0);
    chk("crd20_gnt", c_gnt, 1);
    cyc(); c_req = 0;
    mid();
    chk("crd20_rdata", c_rdata, 32'h1234_5678);

    // Partial write: low two bytes only
    cyc();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hAABB_CCDD; d_be = 4'h3;
    mid();
    chk("pwr_mem_be", mem_be, 4'h3);
    cyc(); d_req = 0;
    c_req = 1; c_we = 0; c_addr = 32'h20;
    cyc(); c_req = 0;
    mid();
    chk("pwr_rdata", c_rdata, 32'h1234_CCDD);

    // Reset arriving while a core read is accepted
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h4;
    mid();
    chk("pre_rst_c_gnt", c_gnt, 1);
    cyc(); d_req = 0; rst = 1;
    mid();
    chk("rst_cyc_c_gnt", c_gnt, 1);
    chk("rst_cyc_c_rdata", c_rdata, 32'hDEAD_BEEF);
    cyc(); rst = 0; c_req = 0;
    mid();
    chk("post_rst_c_rvalid", c_rvalid, 0);
    chk("post_rst_c_rdata", c_rdata, 0);
    chk("post_rst_d_rvalid", d_rvalid, 0);
    chk("post_rst_mem_en", mem_en, 0);
    chk("post_rst_mem_addr", mem_addr, 0);
    chk("post_rst_stall", core_stall, 0);
    cyc();
    c_req = 1; d_req = 1;
    mid();
    chk("post_rst_first_contest", c_gnt, 1);
    cyc(); c_req = 0; d_req = 0;

`ifdef DMEM_ARB_LOCK_EN
    // Locked debug burst: last contest went to core, so debug takes the
    // first cycle by round-robin and then holds the memory via the lock.
    cyc();
    c_req = 1; c_we = 0; c_addr = 32'h0;
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h5; d_be = 4'hF; d_lock = 1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("lock%0d_d_gnt", k), d_gnt, 1);
      chk($sformatf("lock%0d_stall", k), core_stall, 1);
      cyc();
    end
    d_lock = 0;
    mid();
    chk("unlock_d_gnt", d_gnt, 1);
    cyc();
    mid();
    chk("after_unlock_c_gnt", c_gnt, 1);
    chk("after_unlock_d_gnt", d_gnt, 0);
    cyc(); c_req = 0; d_req = 0;
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
